// File: rtl/key_mode_ctl.sv
// key_mode_ctl
// Multi-key push-button front end. Every key gets its own lane with a
// two-flop synchroniser, a debounce counter, a short/long press classifier
// and a wrap-around mode counter. Lanes share nothing but clk and rst.
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : asynchronous active-high reset
//   key          : raw key pins (KEY_NUM), polarity set by KEY_ACTIVE_LOW
//   key_deb      : debounced level per key, 1 = pressed
//   short_pulse  : one-cycle strobe per completed short press
//   long_pulse   : one-cycle strobe when a press reaches LONG_CYCLES
//   mode         : per-key mode counter, key i in bits [i*MW +: MW]
module key_mode_ctl #(
  parameter int KEY_NUM        = 4,
  parameter int DEB_CYCLES     = 20'h7_ffff,
  parameter int LONG_CYCLES    = 24'hFF_FFFF,
  parameter int MODE_NUM       = 2,
  parameter int KEY_ACTIVE_LOW = 1,
  localparam int MW            = (MODE_NUM > 2) ? $clog2(MODE_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_NUM-1:0]    key,
  output logic [KEY_NUM-1:0]    key_deb,
  output logic [KEY_NUM-1:0]    short_pulse,
  output logic [KEY_NUM-1:0]    long_pulse,
  output logic [KEY_NUM*MW-1:0] mode
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = $clog2(LONG_CYCLES);

  localparam logic          REL_LVL   = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(LONG_CYCLES - 2);
  localparam logic [MW-1:0] MODE_LAST = MW'(MODE_NUM - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_LONG  = 2'd2;

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_lane
    logic          sync1_q, sync2_q;
    logic          lvl;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [1:0]    st_q, st_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic [MW-1:0] mode_q, mode_d;

    // Normalise polarity after the synchroniser: lvl = 1 means pressed.
    assign lvl = sync2_q ^ REL_LVL;

    // Debounce: accept a new level only after DEB_CYCLES consecutive
    // differing cycles; any return to the accepted level restarts the count.
    always_comb begin
      deb_d  = deb_q;
      dcnt_d = dcnt_q;
      if (lvl == deb_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DEB_LAST) begin
        deb_d  = lvl;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    // Press classifier and mode counter. IDLE is only ever entered with
    // key_deb low, so seeing it high in IDLE is the 0->1 edge.
    always_comb begin
      st_d    = st_q;
      pcnt_d  = pcnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      mode_d  = mode_q;
      case (st_q)
        S_IDLE: begin
          if (deb_q) begin
            st_d   = S_PRESS;
            pcnt_d = '0;
          end
        end
        S_PRESS: begin
          // Release wins over reaching the long threshold in the same cycle.
          if (!deb_q) begin
            short_d = 1'b1;
            st_d    = S_IDLE;
            mode_d  = (mode_q == MODE_LAST) ? '0 : mode_q + MW'(1);
          end else if (pcnt_q == PCNT_LAST) begin
            long_d = 1'b1;
            st_d   = S_LONG;
            mode_d = '0;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        S_LONG: begin
          if (!deb_q) st_d = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= REL_LVL;
        sync2_q <= REL_LVL;
        deb_q   <= 1'b0;
        dcnt_q  <= '0;
        st_q    <= S_IDLE;
        pcnt_q  <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        mode_q  <= '0;
      end else begin
        sync1_q <= key[k];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        dcnt_q  <= dcnt_d;
        st_q    <= st_d;
        pcnt_q  <= pcnt_d;
        short_q <= short_d;
        long_q  <= long_d;
        mode_q  <= mode_d;
      end
    end

    assign key_deb[k]          = deb_q;
    assign short_pulse[k]      = short_q;
    assign long_pulse[k]       = long_q;
    assign mode[k*MW +: MW]    = mode_q;
  end

endmodule

// File: tb/tb_key_mode_ctl.sv
module tb_key_mode_ctl;

  localparam int KN   = 2;
  localparam int DEB  = 8;
  localparam int LONG = 32;
  localparam int MN   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KN-1:0] key = 2'b11;
  logic [KN-1:0] key_deb, short_pulse, long_pulse;
  logic [3:0]    mode;

  int total = 0;
  int bad   = 0;

  key_mode_ctl #(
    .KEY_NUM(KN), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
    .MODE_NUM(MN), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .key_deb(key_deb),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: works with timestamps of level changes and of the
  // debounced rise rather than counters; the pins reach it through a
  // two-sample delay.
  bit       s1m[KN], s2m[KN], deb_m[KN], lvl_m[KN], act_m[KN], lng_m[KN];
  int       lvl_t[KN], rise_m[KN], mode_m[KN];
  int       mcyc = 0;
  logic [KN-1:0] exp_deb = '0, exp_sp = '0, exp_lp = '0;
  logic [3:0]    exp_mode = '0;

  task automatic model_tick();
    bit lvl;
    if (rst) begin
      for (int k = 0; k < KN; k++) begin
        s1m[k] = 1'b1; s2m[k] = 1'b1; deb_m[k] = 1'b0; lvl_m[k] = 1'b0;
        act_m[k] = 1'b0; lng_m[k] = 1'b0; lvl_t[k] = 0; rise_m[k] = 0;
        mode_m[k] = 0;
      end
      exp_sp = '0;
      exp_lp = '0;
    end else begin
      mcyc++;
      for (int k = 0; k < KN; k++) begin
        lvl = (s2m[k] == 1'b0);
        exp_sp[k] = 1'b0;
        exp_lp[k] = 1'b0;
        if (act_m[k]) begin
          if (!deb_m[k]) begin
            act_m[k] = 1'b0;
            if (!lng_m[k]) begin
              exp_sp[k] = 1'b1;
              mode_m[k] = (mode_m[k] + 1) % MN;
            end
          end else if (!lng_m[k] && (mcyc - rise_m[k] == LONG)) begin
            exp_lp[k] = 1'b1;
            lng_m[k]  = 1'b1;
            mode_m[k] = 0;
          end
        end
        if (lvl != lvl_m[k]) begin
          lvl_m[k] = lvl;
          lvl_t[k] = mcyc;
        end
        if (lvl != deb_m[k] && (mcyc - lvl_t[k] + 1) >= DEB) begin
          deb_m[k] = lvl;
          if (lvl) begin
            act_m[k]  = 1'b1;
            lng_m[k]  = 1'b0;
            rise_m[k] = mcyc;
          end
        end
        s2m[k] = s1m[k];
        s1m[k] = key[k];
      end
    end
    for (int k = 0; k < KN; k++) begin
      exp_deb[k]        = deb_m[k];
      exp_mode[k*2 +: 2] = 2'(mode_m[k]);
    end
  endtask

  always @(posedge clk or posedge rst) model_tick();

  // Per-cycle comparison against the model and pulse bookkeeping.
  int sp_cnt[KN] = '{0, 0};
  int lp_cnt[KN] = '{0, 0};
  int last_sp[KN] = '{0, 0};
  int ncyc = 0;

  always @(negedge clk) begin
    ncyc++;
    chk("deb", 32'(key_deb), 32'(exp_deb));
    chk("short", 32'(short_pulse), 32'(exp_sp));
    chk("long", 32'(long_pulse), 32'(exp_lp));
    chk("mode", 32'(mode), 32'(exp_mode));
    for (int k = 0; k < KN; k++) begin
      if (short_pulse[k]) begin
        sp_cnt[k]++;
        last_sp[k] = ncyc;
      end
      if (long_pulse[k]) lp_cnt[k]++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press0(input int hold);
    key[0] = 1'b0;
    step(hold);
    key[0] = 1'b1;
  endtask

  initial begin
    int s0, l0, s1, lat;
    int rem[KN];

    // Reset with both keys released
    step(4);
    chk("rst_hold", 32'({key_deb, short_pulse, long_pulse, mode}), 32'd0);
    rst = 1'b0;
    step(5);
    chk("rst_rel", 32'({key_deb, short_pulse, long_pulse, mode}), 32'd0);

    // Reset in the middle of a press
    s0 = sp_cnt[0];
    key[0] = 1'b0;
    step(20);
    chk("deb_on", 32'(key_deb[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_deb", 32'(key_deb[0]), 32'd0);
    chk("rst_mid_pulse", 32'({short_pulse, long_pulse}), 32'd0);
    step(2);
    rst = 1'b0;
    step(15);
    key[0] = 1'b1;
    step(30);
    chk("rst_repress", 32'(sp_cnt[0] - s0), 32'd1);

    // Bounce rejection
    s0 = sp_cnt[0];
    l0 = lp_cnt[0];
    for (int i = 0; i < 4; i++) begin
      key[0] = 1'b0;
      step(5);
      key[0] = 1'b1;
      step($urandom_range(5, 10));
    end
    chk("bounce_deb", 32'(key_deb[0]), 32'd0);
    chk("bounce_pulses", 32'((sp_cnt[0] - s0) + (lp_cnt[0] - l0)), 32'd0);
    key[0] = 1'b0;
    lat = 0;
    while (key_deb[0] == 1'b0 && lat < 40) begin
      step(1);
      lat++;
    end
    chk("deb_latency", 32'(lat), 32'd10);
    step(5);
    key[0] = 1'b1;
    step(30);

    // Three short presses wrap the mode counter
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    s0 = sp_cnt[0];
    for (int i = 0; i < 3; i++) begin
      press0(20);
      step(20 + $urandom_range(0, 5));
      chk("wrap_mode0", 32'(mode[1:0]), 32'((i + 1) % MN));
      chk("wrap_mode1", 32'(mode[3:2]), 32'd0);
    end
    chk("wrap_count", 32'(sp_cnt[0] - s0), 32'd3);

    // Long press from mode 2
    press0(20);
    step(25);
    press0(20);
    step(25);
    chk("pre_long_mode", 32'(mode[1:0]), 32'd2);
    s0 = sp_cnt[0];
    l0 = lp_cnt[0];
    key[0] = 1'b0;
    lat = 0;
    while (key_deb[0] == 1'b0 && lat < 40) begin
      step(1);
      lat++;
    end
    lat = 0;
    while (long_pulse[0] == 1'b0 && lat < 100) begin
      step(1);
      lat++;
    end
    chk("long_latency", 32'(lat), 32'd32);
    chk("long_mode", 32'(mode[1:0]), 32'd0);
    step(20);
    key[0] = 1'b1;
    step(30);
    chk("long_no_short", 32'(sp_cnt[0] - s0), 32'd0);
    chk("long_count", 32'(lp_cnt[0] - l0), 32'd1);

    // Long threshold boundary: 31 cycles short, 32 cycles long
    s0 = sp_cnt[0];
    l0 = lp_cnt[0];
    press0(LONG - 1);
    step(30);
    chk("thr31_short", 32'(sp_cnt[0] - s0), 32'd1);
    chk("thr31_long", 32'(lp_cnt[0] - l0), 32'd0);
    press0(LONG);
    step(30);
    chk("thr32_short", 32'(sp_cnt[0] - s0), 32'd1);
    chk("thr32_long", 32'(lp_cnt[0] - l0), 32'd1);

    // Both keys pressed together
    s0 = sp_cnt[0];
    s1 = sp_cnt[1];
    key = 2'b00;
    step(20);
    key = 2'b11;
    step(30);
    chk("conc_k0", 32'(sp_cnt[0] - s0), 32'd1);
    chk("conc_k1", 32'(sp_cnt[1] - s1), 32'd1);
    chk("conc_same_cycle", 32'(last_sp[0]), 32'(last_sp[1]));
    chk("conc_mode", 32'(mode), 32'h5);

    // Random pin activity on both keys with occasional resets
    rem = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < KN; k++) begin
        if (rem[k] == 0) begin
          key[k] = ~key[k];
          rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9)
                                               : $urandom_range(6, 45);
        end else begin
          rem[k]--;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
      step(1);
    end

    key = 2'b11;
    step(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_mode_ctl.md
# key_mode_ctl

Parametrised multi-key front end for the board push-buttons: synchronises and debounces `KEY_NUM` raw key inputs, classifies each press as short or long, and keeps a per-key wrap-around mode counter of configurable modulus. It sits between the key pins and the control logic that selects effects and modes, replacing single-key toggle controllers with one instance serving every key.

## Interface

Parameters:
- `KEY_NUM`, 4: number of independent keys (≥1).
- `DEB_CYCLES`, 20'h7_ffff: consecutive stable synchronised cycles required to accept a level change (≥1).
- `LONG_CYCLES`, 24'hFF_FFFF: debounced-pressed cycles that make a press "long" (≥2).
- `MODE_NUM`, 2: modulus of each mode counter (≥2). `MW = max(1, clog2(MODE_NUM))`.
- `KEY_ACTIVE_LOW`, 1: 1 means the raw pin reads 0 when pressed.

Ports:
- `clk`, input, 1: sole clock; all state is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `key`, input, KEY_NUM: raw asynchronous key pins.
- `key_deb`, output, KEY_NUM: debounced level, 1 = pressed, regardless of `KEY_ACTIVE_LOW`.
- `short_pulse`, output, KEY_NUM: 1-cycle strobe per completed short press.
- `long_pulse`, output, KEY_NUM: 1-cycle strobe when a press reaches long duration.
- `mode`, output, KEY_NUM*MW: per-key mode counter, key i in bits [i*MW +: MW].

## Operation

Every key has an identical, fully independent lane:
- Synchroniser: two flops. Reset to the released pin level (1 if `KEY_ACTIVE_LOW`, else 0). Polarity is normalised after the second flop.
- Debounce: counter `dcnt`. If the synchronised level equals `key_deb`, clear `dcnt`. Otherwise increment. When `dcnt == DEB_CYCLES-1` and the level still differs, update `key_deb` and clear `dcnt`. Any glitch shorter than `DEB_CYCLES` cycles clears `dcnt` and causes no change.
- Press FSM, with states IDLE, PRESS and LONG:
  - IDLE → PRESS on `key_deb` 0→1. Clear `pcnt`.
  - PRESS, with `key_deb` = 0: assert `short_pulse` and go to IDLE. Release is checked first.
  - PRESS, with `pcnt == LONG_CYCLES-2`: assert `long_pulse` and go to LONG.
  - PRESS, otherwise: `pcnt`++.
  - LONG → IDLE on `key_deb` = 0, with no pulse.
- `pcnt` width is `clog2(LONG_CYCLES)`. It never wraps.
- Mode counter:
  - On a short press, `mode` advances by one. After `MODE_NUM-1` it wraps to 0.
  - On a long press, `mode` is forced to 0.
  - The new value is registered on the same edge that raises the pulse, so it is visible in the pulse cycle.
- Reset values: `key_deb` = 0, `short_pulse` = 0, `long_pulse` = 0, `mode` = 0, FSM = IDLE, `dcnt` = 0, `pcnt` = 0.
- Reset mid-press: lane state is lost with no pulse emitted. A key still held after reset is re-debounced and treated as a new press.
- Simultaneous events on different keys are handled independently in the same cycle. There is no priority or arbitration.

## Timing

- Pin-change latency: the synchronised level changes 2 cycles after the pin is sampled. `key_deb` then changes `DEB_CYCLES` cycles later, provided the level stays stable.
- Pulse latency:
  - `short_pulse` is high in the cycle after the first cycle in which `key_deb` = 0 is seen in PRESS.
  - `long_pulse` is high exactly `LONG_CYCLES` cycles after the `key_deb` rising edge, if the key is held.
- Pulses are exactly one cycle wide. Each press yields at most one pulse, never both kinds.
- Boundaries:
  - A press lasting `LONG_CYCLES-1` debounced cycles gives a short pulse.
  - A press lasting `LONG_CYCLES` cycles gives a long pulse.
  - A release in the cycle the long threshold is reached counts as short, because release is checked first.

## Test plan

Use `KEY_NUM`=2, `DEB_CYCLES`=8, `LONG_CYCLES`=32, `MODE_NUM`=3, `KEY_ACTIVE_LOW`=1.

- Reset check: assert `rst` with `key`=2'b11. All outputs are 0 during reset and after release. Then assert `rst` mid-press on key0: `key_deb[0]` returns to 0 immediately, and no pulse appears.
- Bounce rejection: toggle `key[0]` low for 5-cycle bursts. `key_deb[0]` stays 0 with no pulses. Then hold it low: `key_deb[0]` rises 10 cycles after the pin edge, with ±1 cycle for sampling phase.
- Short press and wrap: perform three clean presses on key0, each held 20 cycles. Exactly 3 `short_pulse[0]` strobes occur. `mode[1:0]` goes 1, 2, 0. `mode[3:2]` stays 0.
- Long press: with key0 `mode`=2, hold key0 for 60 cycles. `long_pulse[0]` occurs 32 cycles after the `key_deb[0]` rise, and `mode[1:0]`=0. There is no `short_pulse[0]` on release.
- Threshold edge: a press with 31 debounced-high cycles gives one `short_pulse`. A press with exactly 32 cycles gives one `long_pulse`.
- Concurrency: press key0 and key1 in the same cycle, each for 20 cycles. Both `short_pulse` bits occur in the same cycle, and both modes become 1.
